// File: rtl/tube_scan_ctrl.sv
// Multiplexed seven-segment scanner for 1..8 digits with hex or unsigned-decimal display.
// Decimal values go through a sequential double-dabble converter; the display keeps the last result.
module tube_scan_ctrl #(
  parameter int unsigned N_DIGITS = 8,
  parameter int unsigned SCAN_DIV = 12500
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         data_in,
  input  logic                mode,
  input  logic                lz_blank,
  input  logic [N_DIGITS-1:0] dp_mask,
  output logic                busy,
  output logic [N_DIGITS-1:0] tube_scan,
  output logic [7:0]          tube_signal_right,
  output logic [7:0]          tube_signal_left
);

  localparam int unsigned DivW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [2:0]      IdxLast = 3'(N_DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StShift, StCommit, StDone} conv_st_e;

  conv_st_e            state_q, state_d;
  logic [31:0]         bin_q, bin_d;
  logic [39:0]         work_q, work_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [39:0]         bcd_q, bcd_d;
  logic [31:0]         cap_val_q, cap_val_d;
  logic                cap_mode_q, cap_mode_d;
  logic                cap_valid_q, cap_valid_d;
  logic                busy_q, busy_d;

  logic [DivW-1:0]     div_q, div_d;
  logic [2:0]          idx_q, idx_d;
  logic [N_DIGITS-1:0] scan_q, scan_d;
  logic [7:0]          seg_r_q, seg_r_d;
  logic [7:0]          seg_l_q, seg_l_d;

  logic                conv_start;

  function automatic logic [39:0] dabble_step(input logic [39:0] bcd, input logic msb);
    logic [39:0] t;
    t = bcd;
    for (int i = 0; i < 10; i++) begin
      if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
    end
    return {t[38:0], msb};
  endfunction

  function automatic logic [7:0] glyph(input logic [3:0] nib);
    logic [7:0] g;
    g = 8'h00;
    unique case (nib)
      4'h0: g = 8'hFC;
      4'h1: g = 8'h60;
      4'h2: g = 8'hDA;
      4'h3: g = 8'hF2;
      4'h4: g = 8'h66;
      4'h5: g = 8'hB6;
      4'h6: g = 8'hBE;
      4'h7: g = 8'hE0;
      4'h8: g = 8'hFE;
      4'h9: g = 8'hF6;
      4'hA: g = 8'hEE;
      4'hB: g = 8'h3E;
      4'hC: g = 8'h9C;
      4'hD: g = 8'h7A;
      4'hE: g = 8'h9E;
      4'hF: g = 8'h8E;
    endcase
    return g;
  endfunction

  // Captured mode tracks the input while idle so that re-entering decimal mode forces a conversion.
  assign conv_start = (state_q == StIdle) && mode &&
                      (({mode, data_in} != {cap_mode_q, cap_val_q}) || !cap_valid_q);

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;
    cap_val_d   = cap_val_q;
    cap_mode_d  = cap_mode_q;
    cap_valid_d = cap_valid_q;
    busy_d      = busy_q;
    unique case (state_q)
      StIdle: begin
        if (conv_start) begin
          cap_val_d   = data_in;
          cap_mode_d  = mode;
          cap_valid_d = 1'b1;
          bin_d       = data_in;
          work_d      = '0;
          cnt_d       = '0;
          busy_d      = 1'b1;
          state_d     = StShift;
        end else begin
          cap_mode_d = mode;
        end
      end
      StShift: begin
        work_d = dabble_step(work_q, bin_q[31]);
        bin_d  = {bin_q[30:0], 1'b0};
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StCommit;
      end
      StCommit: begin
        bcd_d   = work_q;
        state_d = StDone;
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  logic [3:0] cur_dig;
  logic [3:0] nib;
  logic       cur_dp;
  logic       upper_zero;
  logic       ovf;
  logic [7:0] seg;

  always_comb begin
    div_d = div_q + DivW'(1);
    idx_d = idx_q;
    if (div_q == DivLast) begin
      div_d = '0;
      idx_d = (idx_q == IdxLast) ? 3'd0 : idx_q + 3'd1;
    end

    cur_dig    = '0;
    cur_dp     = 1'b0;
    nib        = '0;
    upper_zero = 1'b1;
    scan_d     = '0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      nib       = mode ? bcd_q[4*k +: 4] : data_in[4*k +: 4];
      scan_d[k] = (3'(k) == idx_q);
      if (3'(k) == idx_q) begin
        cur_dig = nib;
        cur_dp  = dp_mask[k];
      end
      if (3'(k) >= idx_q && nib != 4'd0) upper_zero = 1'b0;
    end

    // Decimal digits that do not fit on the display turn the whole display into dashes.
    ovf = 1'b0;
    for (int unsigned j = 0; j < 10; j++) begin
      if (j >= N_DIGITS && bcd_q[4*j +: 4] != 4'd0) ovf = mode;
    end

    if (ovf)                                          seg = 8'h02;
    else if (lz_blank && idx_q != 3'd0 && upper_zero) seg = 8'h00;
    else                                              seg = glyph(cur_dig);
    seg[0] = seg[0] | cur_dp;

    seg_r_d = (idx_q < 3'd4) ? seg : 8'h00;
    seg_l_d = (idx_q < 3'd4) ? 8'h00 : seg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      bin_q       <= '0;
      work_q      <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      cap_val_q   <= '0;
      cap_mode_q  <= 1'b0;
      cap_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      div_q       <= '0;
      idx_q       <= '0;
      scan_q      <= '0;
      seg_r_q     <= '0;
      seg_l_q     <= '0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      cap_val_q   <= cap_val_d;
      cap_mode_q  <= cap_mode_d;
      cap_valid_q <= cap_valid_d;
      busy_q      <= busy_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
      scan_q      <= scan_d;
      seg_r_q     <= seg_r_d;
      seg_l_q     <= seg_l_d;
    end
  end

  assign busy              = busy_q;
  assign tube_scan         = scan_q;
  assign tube_signal_right = seg_r_q;
  assign tube_signal_left  = seg_l_q;

endmodule

// File: tb/tb_tube_scan_ctrl.sv
// Scoreboard bench for tube_scan_ctrl: an 8-digit instance (SCAN_DIV=2) and a 4-digit one
// (SCAN_DIV=1); expected frames come from an arithmetic reference model.
module tb_tube_scan_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mode, lz_blank, busy;
  logic [31:0] data_in;
  logic [7:0]  dp_mask, tube_scan, right, left;

  logic        rst4, busy4;
  logic [31:0] data4;
  logic [3:0]  dp4, scan4;
  logic [7:0]  right4, left4;

  tube_scan_ctrl #(.N_DIGITS(8), .SCAN_DIV(2)) u_dut8 (
    .clk               (clk),
    .rst               (rst),
    .data_in           (data_in),
    .mode              (mode),
    .lz_blank          (lz_blank),
    .dp_mask           (dp_mask),
    .busy              (busy),
    .tube_scan         (tube_scan),
    .tube_signal_right (right),
    .tube_signal_left  (left)
  );

  tube_scan_ctrl #(.N_DIGITS(4), .SCAN_DIV(1)) u_dut4 (
    .clk               (clk),
    .rst               (rst4),
    .data_in           (data4),
    .mode              (1'b0),
    .lz_blank          (1'b0),
    .dp_mask           (dp4),
    .busy              (busy4),
    .tube_scan         (scan4),
    .tube_signal_right (right4),
    .tube_signal_left  (left4)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb[$];

  logic [7:0] glyph_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] got);
    sb_t e;
    if (sb.size() == 0) begin
      check_val("sb_underflow", 32'(sb.size()), 1);
    end else begin
      e = sb.pop_front();
      check_val(e.tag, got, e.exp);
    end
  endtask

  // Reference: decimal digits by division, overflow when the value needs more than nd digits.
  function automatic logic [7:0] exp_seg(input logic [31:0] val, input bit dec, input bit lz,
                                         input logic [7:0] dp, input int k, input int nd);
    longint unsigned v, p;
    logic [3:0] dg [8];
    int hi;
    logic [7:0] g;
    v = val;
    p = 1;
    hi = 0;
    for (int j = 0; j < 8; j++) dg[j] = 4'd0;
    for (int j = 0; j < nd; j++) begin
      if (dec) dg[j] = 4'((v / p) % 10);
      else     dg[j] = val[4*j +: 4];
      p = p * 10;
      if (dg[j] != 4'd0) hi = j;
    end
    if (dec && v >= p)    g = 8'h02;
    else if (lz && k > hi) g = 8'h00;
    else                  g = glyph_tab[dg[k]];
    g[0] = g[0] | dp[k];
    return g;
  endfunction

  function automatic logic [15:0] frame(input logic [7:0] seg, input int k);
    return (k < 4) ? {8'h00, seg} : {seg, 8'h00};
  endfunction

  task automatic read_digit(input int k, output logic [15:0] lr);
    logic [7:0] want;
    bit found;
    want  = 8'(1) << k;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tube_scan == want) begin
        found = 1;
        break;
      end
    end
    lr = found ? {left, right} : 16'hxxxx;
  endtask

  task automatic wait_rise(output bit ok);
    ok = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy) begin
        ok = 1;
        break;
      end
    end
  endtask

  // Counts busy-high samples, starting from one already observed high.
  task automatic count_busy(input int poke_at, input logic [31:0] poke_val, output int n);
    n = 1;
    for (int i = 0; i < 100; i++) begin
      if (n == poke_at) data_in = poke_val;
      @(negedge clk);
      if (!busy) break;
      n++;
    end
  endtask

  task automatic check_digits(input string tag, input logic [31:0] val, input bit lz, input int nd);
    logic [15:0] lr;
    for (int k = 0; k < nd; k++) sb_push(tag, 32'(frame(exp_seg(val, 1, lz, 8'h00, k, 8), k)));
    for (int k = 0; k < nd; k++) begin
      read_digit(k, lr);
      sb_check(32'(lr));
    end
  endtask

  task automatic convert(input string tag, input logic [31:0] val);
    bit ok;
    int n;
    data_in = val;
    wait_rise(ok);
    check_val({tag, "_rise"}, 32'(ok), 1);
    sb_push({tag, "_busy_len"}, 34);
    count_busy(0, 0, n);
    sb_check(32'(n));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] lr;
    bit ok;
    int n;
    int d;

    rst = 1'b1; rst4 = 1'b1; mode = 1'b0; lz_blank = 1'b0; dp_mask = 8'h00;
    data_in = 32'h1234ABCD; data4 = 32'h0; dp4 = 4'b0010;
    repeat (3) @(negedge clk);

    sb_push("reset_out8", 0);
    sb_check({7'd0, busy, tube_scan, left, right});
    sb_push("reset_out4", 0);
    sb_check({11'd0, busy4, scan4, left4, right4});

    // Hex scan after reset release; each digit holds for two cycles.
    for (int i = 1; i <= 18; i++) begin
      d = ((i - 1) / 2) % 8;
      sb_push("hex_scan", {8'd0, 8'(1) << d, frame(exp_seg(data_in, 0, 0, 8'h00, d, 8), d)});
    end
    rst = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      sb_check({8'd0, tube_scan, left, right});
    end

    mode = 1'b1;
    convert("dec", 32'd12345678);
    check_digits("dec_digit", 32'd12345678, 0, 8);

    convert("ovf", 32'd100000000);
    check_digits("ovf_digit", 32'd100000000, 0, 8);

    lz_blank = 1'b1;
    convert("lz", 32'd42);
    check_digits("lz_digit", 32'd42, 1, 8);
    lz_blank = 1'b0;

    // data_in changes on the 10th busy cycle; the first result must still be 5.
    data_in = 32'd5;
    wait_rise(ok);
    check_val("chg_rise", 32'(ok), 1);
    sb_push("chg_busy_len", 34);
    count_busy(10, 32'd7, n);
    sb_check(32'(n));
    @(negedge clk);
    check_val("chg_restart", 32'(busy), 1);
    sb_push("chg_first", 32'(frame(exp_seg(32'd5, 1, 0, 8'h00, 0, 8), 0)));
    read_digit(0, lr);
    sb_check(32'(lr));
    count_busy(0, 0, n);
    check_val("chg_second_done", 32'(n < 100), 1);
    sb_push("chg_second", 32'(frame(exp_seg(32'd7, 1, 0, 8'h00, 0, 8), 0)));
    read_digit(0, lr);
    sb_check(32'(lr));

    // Reset at busy cycle 20 discards the conversion; a fresh one follows release.
    data_in = 32'd99;
    wait_rise(ok);
    check_val("rstc_rise", 32'(ok), 1);
    n = 1;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      if (busy) n++;
    end
    check_val("rstc_at20", 32'(n), 20);
    rst = 1'b1;
    @(negedge clk);
    sb_push("rstc_out", 0);
    sb_check({7'd0, busy, tube_scan, left, right});
    rst = 1'b0;
    convert("rstc_fresh", 32'd99);
    check_digits("rstc_digit", 32'd99, 0, 3);

    // Leaving decimal mode mid-conversion shows hex at once; re-entering reconverts.
    data_in = 32'h4D;
    wait_rise(ok);
    check_val("mchg_rise", 32'(ok), 1);
    mode = 1'b0;
    sb_push("mchg_hex", 32'(frame(exp_seg(32'h4D, 0, 0, 8'h00, 0, 8), 0)));
    read_digit(0, lr);
    sb_check(32'(lr));
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    check_val("mchg_idle", 32'(busy), 0);
    @(negedge clk);
    mode = 1'b1;
    convert("mchg_reenter", 32'h4D);
    check_digits("mchg_digit", 32'h4D, 0, 2);

    // Four-digit instance: scan 1,2,4,8 every cycle, dp on digit 1, left bus idle.
    for (int i = 1; i <= 12; i++) begin
      d = (i - 1) % 4;
      sb_push("w4_scan", {12'd0, 4'(1 << d), 8'h00, exp_seg(32'h0, 0, 0, 8'b0000_0010, d, 4)});
    end
    rst4 = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      sb_check({12'd0, scan4, left4, right4});
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
